ap_delay_bank: RTL
==================

# ap_delay_bank

Per-channel storage for the adaptive-predictor speed-control state AP in the multi-channel ADPCM datapath. Sits directly downstream of the FILTC stage: it takes each channel's filtered value APP and the tone/transition trigger TR, applies the TRIGA rule (TR forces AP to 256), and holds the result. On the channel's next sample it returns that value as AP, which is fed back into FILTC and forward to speed control. It also clears every channel's state after reset.

## Interface
Parameters:
- NCH, 32, number of channels held; 2..32.
- CH_W, 5, channel index width; must satisfy 2^CH_W >= NCH.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  synchronous, active-low reset.
- wr_en  input  1  write strobe for one channel's new state.
- wr_ch  input  CH_W  channel being written.
- APP  input  10  FILTC output for wr_ch.
- TR  input  1  trigger for wr_ch; 1 forces stored AP to 256.
- rd_en  input  1  read request.
- rd_ch  input  CH_W  channel being read.
- AP  output  10  stored AP for the last accepted read.
- ap_valid  output  1  single-cycle pulse; AP is valid.
- ap_ch  output  CH_W  channel that AP belongs to.
- init_busy  output  1  clear sweep in progress; all requests ignored.

## Operation
- Storage is NCH × 10-bit entries, with one entry per channel.
- Write: when wr_en=1 and init_busy=0, store entry[wr_ch] = TR ? 10'd256 : APP. APP is stored unmodified; no masking or saturation.
- Read: when rd_en=1 and init_busy=0, return entry[rd_ch] on AP, ap_ch=rd_ch and ap_valid=1 in the following cycle.
- A channel index >= NCH is out of range. A write to it is dropped. A read of it returns AP=0 with ap_valid=1.
- Reads and writes are independent and may occur in the same cycle.
- State machine:
  - INIT: entered while reset=0. Clears entry[k] to 0 at k = 0..NCH-1, one entry per cycle. Moves to RUN after the clear of entry NCH-1.
  - RUN: normal operation. Leaves RUN only on reset.
- Reset asserted mid-sweep or in RUN restarts the sweep at k=0.
- Reset values:
  - AP = 0, ap_valid = 0, ap_ch = 0.
  - init_busy = 1.
  - Sweep counter = 0.

## Timing
- Read latency is 1 cycle: request at edge n gives AP/ap_valid registered at edge n+1.
- A write takes effect at its edge. A read of the same channel issued in a later cycle returns the new value.
- Same-cycle read and write to the same channel: behaviour depends on the macro (see Configuration).
- The sweep takes exactly NCH cycles after reset is released:
  - init_busy = 1 from reset through the clear of entry NCH-1.
  - init_busy falls on the following edge.
- Requests made while init_busy=1 are dropped: no ap_valid, no write.
- No backpressure. One request per port per cycle is accepted indefinitely.

## Configuration
- AP_BYPASS_EN defined: a same-cycle read and write to the same channel returns the newly written value, i.e. TR ? 256 : APP.
- AP_BYPASS_EN undefined: the same case returns the old stored value. The write still lands.

## Structure
- Shared package holds:
  - AP_W = 10.
  - TRIG_AP = 10'd256.
  - The INIT/RUN state enum.
- Sub-module `triga`: combinational 10-bit mux, TR ? TRIG_AP : APP. It is instantiated once on the write path and is reusable in single-channel builds.
- Storage is a register array. No memory macro is required.

## Test plan
- Sweep length: write 10'h3FF to every channel, then pulse reset low for 1 cycle → init_busy high for exactly NCH cycles, then every channel reads AP=0.
- Basic write/read: wr ch5 APP=10'h1A3 TR=0; next cycle rd ch5 → one cycle later AP=10'h1A3, ap_ch=5, ap_valid=1 for one cycle.
- Trigger: wr ch7 APP=10'h3FF TR=1; rd ch7 → AP=10'h100. Then wr ch7 APP=10'h055 TR=0; rd ch7 → AP=10'h055.
- Collision: ch3 holds 10'h010; same-cycle wr ch3 APP=10'h2C0 TR=0 and rd ch3 → AP=10'h2C0 with AP_BYPASS_EN, AP=10'h010 without. A following rd ch3 returns 10'h2C0 in both builds.
- Busy and range: rd/wr requests during the sweep give no ap_valid and leave storage at 0 afterwards. With NCH=20, rd ch25 → AP=0, ap_valid=1; wr ch25 changes no entry.
- Mid-sweep reset: assert reset at sweep cycle 10 → sweep restarts at k=0; init_busy stays high for the full NCH cycles after release.

Source files
------------

// File: rtl/ap_delay_bank_pkg.sv
// Shared types and constants for the per-channel AP delay bank.
// AP_W is the adaptive-predictor speed-control width; TRIG_AP is the value forced by a trigger.
package ap_delay_bank_pkg;

    localparam int AP_W = 10;
    localparam logic [AP_W-1:0] TRIG_AP = 10'd256;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } apState_e;

endpackage

// File: rtl/ap_delay_bank_triga.sv
// TRIGA rule: a tone/transition trigger forces AP to TRIG_AP, otherwise the
// FILTC output passes through untouched. Purely combinational.
module triga
    import ap_delay_bank_pkg::*;
(
    input  logic            tr_i,
    input  logic [AP_W-1:0] app_i,
    output logic [AP_W-1:0] ap_o
);

    assign ap_o = tr_i ? TRIG_AP : app_i;

endmodule

// File: rtl/ap_delay_bank.sv
// Per-channel AP storage with a post-reset clear sweep and one-cycle read latency.
// Optional macro AP_BYPASS_EN: a same-cycle read/write of one channel returns the new value.
module ap_delay_bank
    import ap_delay_bank_pkg::*;
#(
    parameter int NCH  = 32,
    parameter int CH_W = 5
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [CH_W-1:0] wr_ch,
    input  logic [AP_W-1:0] APP,
    input  logic            TR,
    input  logic            rd_en,
    input  logic [CH_W-1:0] rd_ch,
    output logic [AP_W-1:0] AP,
    output logic            ap_valid,
    output logic [CH_W-1:0] ap_ch,
    output logic            init_busy
);

    localparam logic [31:0] NCH_U = NCH;

    logic [AP_W-1:0] entry_q [NCH];

    apState_e        state_q;
    logic [CH_W-1:0] sweepCnt_q;
    logic            initBusy_q;

    logic [AP_W-1:0] ap_q;
    logic            apValid_q;
    logic [CH_W-1:0] apCh_q;

    logic [AP_W-1:0] wrValue;
    logic            wrInRange;
    logic            rdInRange;
    logic            wrAccept;
    logic            rdAccept;
    logic [AP_W-1:0] rdData_d;

    triga uTriga (
        .tr_i  (TR),
        .app_i (APP),
        .ap_o  (wrValue)
    );

    assign wrInRange = (32'(wr_ch) < NCH_U);
    assign rdInRange = (32'(rd_ch) < NCH_U);
    assign wrAccept  = reset && !initBusy_q && wr_en && wrInRange;
    assign rdAccept  = reset && !initBusy_q && rd_en;

    // Out-of-range reads still answer, but always with zero.
    always_comb begin
        rdData_d = '0;
        if (rdInRange) begin
`ifdef AP_BYPASS_EN
            if (wrAccept && (wr_ch == rd_ch)) begin
                rdData_d = wrValue;
            end else begin
                rdData_d = entry_q[rd_ch];
            end
`else
            rdData_d = entry_q[rd_ch];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            sweepCnt_q <= '0;
            initBusy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (32'(sweepCnt_q) == NCH_U - 32'd1) begin
                        state_q    <= ST_RUN;
                        sweepCnt_q <= '0;
                        initBusy_q <= 1'b0;
                    end else begin
                        sweepCnt_q <= sweepCnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    initBusy_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_INIT;
                end
            endcase
        end
    end

    // Storage is never reset directly; the sweep clears it one entry per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state_q == ST_INIT) begin
                entry_q[sweepCnt_q] <= '0;
            end else if (wrAccept) begin
                entry_q[wr_ch] <= wrValue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ap_q      <= '0;
            apValid_q <= 1'b0;
            apCh_q    <= '0;
        end else begin
            apValid_q <= rdAccept;
            if (rdAccept) begin
                ap_q   <= rdData_d;
                apCh_q <= rd_ch;
            end
        end
    end

    assign AP        = ap_q;
    assign ap_valid  = apValid_q;
    assign ap_ch     = apCh_q;
    assign init_busy = initBusy_q;

endmodule
